seq_chain_acc: RTL and testbench

SEQ_CHAIN_ACC -- requirements
Module: seq_chain_acc

---
 rtl/seq_chain_pkg.sv | 23 ++
 rtl/seq_hold_timer.sv | 33 +++
 rtl/seq_chain_acc.sv | 163 ++++++++++++++++
 tb/tb_seq_chain_acc.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_chain_pkg.sv
// seq_chain_acc shared types and defaults.
// State enum, default parameters, channel-index width helper.
package seq_chain_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STAGE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CH    = 4;
  localparam int DEF_HOLD  = 10;
  localparam int DEF_ITERS = 1;

  localparam int HOLD_W = 10;
  localparam int ITER_W = 8;

  function automatic int chw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_hold_timer.sv
// Loadable down-counter for channel stage timing.
// expire pulses when the count hits zero; it then reloads HOLD-1.
module seq_hold_timer
  import seq_chain_pkg::*;
#(
  parameter int HOLD = DEF_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [HOLD_W-1:0] load_val,
  input  logic              en,
  output logic              expire
);

  localparam logic [HOLD_W-1:0] RELOAD = HOLD_W'(HOLD - 1);

  logic [HOLD_W-1:0] cnt;

  assign expire = en && (cnt == '0);

  // count down while enabled, wrap to HOLD-1 on expiry
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
    end
  end

endmodule

// File: rtl/seq_chain_acc.sv
// Sequential per-channel accumulator, HOLD cycles per channel stage.
// Define SEQ_CHAIN_SAT_EN for saturating adds (default: wrap).
module seq_chain_acc
  import seq_chain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CH    = DEF_CH,
  parameter int HOLD  = DEF_HOLD,
  parameter int ITERS = DEF_ITERS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clr,
  input  logic [CH*WIDTH-1:0]   inc_bus,
  output logic [CH*WIDTH-1:0]   acc_bus,
  output logic                  busy,
  output logic                  done,
  output logic [chw(CH)-1:0]    ch_idx
);

  localparam int CW = chw(CH);
  localparam logic [CW-1:0] LAST_CH = CW'(CH - 1);
  localparam logic [ITER_W-1:0] LAST_IT = ITER_W'(ITERS - 1);

  state_t state, nstate;

  logic [ITER_W-1:0] iter;
  logic              fresh;
  logic              expire;
  logic              tload;
  logic              ten;
  logic              upd;
  logic              step;
  logic [CW-1:0]     upd_ch;
  logic [CW-1:0]     nxt_ch;
  logic [WIDTH-1:0]  acc [CH];

`ifdef SEQ_CHAIN_SAT_EN
  function automatic logic [WIDTH-1:0] add_ch(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH] ? '1 : s[WIDTH-1:0];
  endfunction
`else
  function automatic logic [WIDTH-1:0] add_ch(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    return a + b;
  endfunction
`endif

  assign nxt_ch = (ch_idx == LAST_CH) ? '0 : ch_idx + 1'b1;

  seq_hold_timer #(
    .HOLD(HOLD)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tload),
    .load_val('0),
    .en      (ten),
    .expire  (expire)
  );

  // next state and per-edge update controls
  always_comb begin
    nstate = state;
    tload  = 1'b0;
    ten    = 1'b0;
    upd    = 1'b0;
    step   = 1'b0;
    upd_ch = ch_idx;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          nstate = S_STAGE;
          tload  = 1'b1;
        end
      end
      S_STAGE: begin
        ten = 1'b1;
        if (expire) begin
          if (fresh) begin
            upd = 1'b1;
          end else if (ch_idx == LAST_CH && iter == LAST_IT) begin
            nstate = S_DONE;
          end else begin
            upd    = 1'b1;
            step   = 1'b1;
            upd_ch = nxt_ch;
          end
        end
      end
      S_DONE: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // state register; clr forces idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= nstate;
    end
  end

  // channel index, iteration and first-update flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      ch_idx <= '0;
      iter   <= '0;
      fresh  <= 1'b0;
    end else if (clr) begin
      ch_idx <= '0;
      iter   <= '0;
      fresh  <= 1'b0;
    end else if (tload) begin
      ch_idx <= '0;
      iter   <= '0;
      fresh  <= 1'b1;
    end else if (upd) begin
      fresh <= 1'b0;
      if (step) begin
        ch_idx <= nxt_ch;
        if (ch_idx == LAST_CH) begin
          iter <= iter + 1'b1;
        end
      end
    end else if (state == S_DONE) begin
      ch_idx <= '0;
      iter   <= '0;
    end
  end

  // accumulate the selected channel on its update edge
  always_ff @(posedge clk) begin
    for (int p = 0; p < CH; p++) begin
      if (!rst) begin
        acc[p] <= '0;
      end else if (clr) begin
        acc[p] <= '0;
      end else if (upd && upd_ch == CW'(p)) begin
        acc[p] <= add_ch(acc[p], inc_bus[p*WIDTH +: WIDTH]);
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign acc_bus[g*WIDTH +: WIDTH] = acc[g];
  end

  assign busy = (state == S_STAGE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_chain_acc.sv
// Self-checking bench for seq_chain_acc.
// Timing table plus scoreboard of final accumulator values.
module tb_seq_chain_acc;

  localparam int W  = 8;
  localparam int C  = 4;
  localparam int H  = 10;
  localparam int IT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        start;
  logic        start2;
  logic [31:0] inc;
  logic [31:0] inc2;
  logic [31:0] acc;
  logic [31:0] acc2;
  logic        busy;
  logic        done;
  logic        busy2;
  logic        done2;
  logic [1:0]  chi;
  logic [1:0]  chi2;

  int total = 0;
  int bad   = 0;

  logic [31:0] sbq[$];
  logic [7:0]  m[4];

  typedef struct {
    int off;
    int ch;
    int val;
    bit busy;
    bit done;
  } vec_t;

  vec_t tab[12];

  always #5 clk = ~clk;

  seq_chain_acc #(
    .WIDTH(W), .CH(C), .HOLD(H), .ITERS(IT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr),
    .inc_bus(inc), .acc_bus(acc), .busy(busy),
    .done(done), .ch_idx(chi)
  );

  seq_chain_acc #(
    .WIDTH(W), .CH(C), .HOLD(1), .ITERS(1)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .clr(clr),
    .inc_bus(inc2), .acc_bus(acc2), .busy(busy2),
    .done(done2), .ch_idx(chi2)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] madd(input logic [7:0] a,
                                      input logic [7:0] b);
    int s;
    s = int'(a) + int'(b);
`ifdef SEQ_CHAIN_SAT_EN
    if (s > 255) s = 255;
`endif
    return 8'(s);
  endfunction

  task automatic predict(input logic [31:0] v);
    for (int p = 0; p < C; p++)
      for (int j = 0; j < IT; j++)
        m[p] = madd(m[p], v[p*8 +: 8]);
    sbq.push_back({m[3], m[2], m[1], m[0]});
  endtask

  task automatic model_clear;
    for (int p = 0; p < C; p++) m[p] = 8'd0;
  endtask

  task automatic do_clr;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear();
    tick();
  endtask

  task automatic run1(input logic [31:0] v,
                      input bit use_tab,
                      input bit repulse);
    logic [31:0] e;
    inc   = v;
    start = 1'b1;
    predict(v);
    tick();
    start = 1'b0;
    for (int off = 0; off <= 90; off++) begin
      if (use_tab) begin
        for (int i = 0; i < 12; i++) begin
          if (tab[i].off == off) begin
            chk($sformatf("acc%0d@%0d", tab[i].ch, off),
                32'(acc[tab[i].ch*8 +: 8]), tab[i].val);
            chk($sformatf("busy@%0d", off), 32'(busy),
                32'(tab[i].busy));
            chk($sformatf("done@%0d", off), 32'(done),
                32'(tab[i].done));
          end
        end
      end
      if (done) begin
        chk("done_off", off, 81);
        if (sbq.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("final_acc", acc, e);
        end
      end
      start = repulse && (off == 4 || off == 39);
      tick();
    end
    start = 1'b0;
    if (sbq.size() != 0) begin
      chk("done_seen", 0, 1);
      sbq.delete();
    end
  endtask

  initial begin
    logic [31:0] e2;
    int ndone;

    tab = '{
      '{0,  0, 0,  1'b1, 1'b0},
      '{1,  0, 11, 1'b1, 1'b0},
      '{10, 1, 0,  1'b1, 1'b0},
      '{11, 1, 10, 1'b1, 1'b0},
      '{21, 2, 3,  1'b1, 1'b0},
      '{31, 3, 7,  1'b1, 1'b0},
      '{40, 0, 11, 1'b1, 1'b0},
      '{41, 0, 22, 1'b1, 1'b0},
      '{71, 3, 14, 1'b1, 1'b0},
      '{80, 3, 14, 1'b1, 1'b0},
      '{81, 3, 14, 1'b0, 1'b1},
      '{82, 0, 22, 1'b0, 1'b0}
    };

    rst    = 1'b0;
    clr    = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    inc    = '0;
    inc2   = '0;
    model_clear();
    tick();
    tick();
    chk("rst_acc", acc, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ch", 32'(chi), 0);
    rst = 1'b1;

    run1(32'h07030A0B, 1'b1, 1'b0);

    do_clr();
    chk("clr_acc", acc, 0);
    run1(32'h07030A0B, 1'b1, 1'b1);

    do_clr();
    run1(32'h000000C8, 1'b0, 1'b0);
`ifdef SEQ_CHAIN_SAT_EN
    chk("sat_acc0", 32'(acc[7:0]), 255);
`else
    chk("wrap_acc0", 32'(acc[7:0]), 144);
`endif

    inc   = 32'h01020304;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 24; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_clear();
    chk("mrst_acc", acc, 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_ch", 32'(chi), 0);
    ndone = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("mrst_nodone", ndone, 0);
    run1(32'h01020304, 1'b0, 1'b0);

    inc   = 32'h05050505;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_clear();
    chk("mclr_acc", acc, 0);
    chk("mclr_busy", 32'(busy), 0);
    ndone = 0;
    for (int i = 0; i < 90; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("mclr_nodone", ndone, 0);

    run1(32'h01010101, 1'b0, 1'b0);
    clr   = 1'b1;
    start = 1'b1;
    tick();
    clr   = 1'b0;
    start = 1'b0;
    model_clear();
    chk("clrst_acc", acc, 0);
    chk("clrst_busy", 32'(busy), 0);
    tick();
    chk("clrst_idle", 32'(busy), 0);

    inc2   = 32'h01010101;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("h1_acc@0", acc2, 0);
    chk("h1_busy@0", 32'(busy2), 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      e2 = '0;
      for (int p = 0; p < C; p++)
        if (p < k) e2[p*8 +: 8] = 8'd1;
      chk($sformatf("h1_acc@%0d", k), acc2, e2);
      chk($sformatf("h1_done@%0d", k), 32'(done2),
          (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("h1_busy@%0d", k), 32'(busy2),
          (k == 5) ? 32'd0 : 32'd1);
    end
    tick();
    chk("h1_done_end", 32'(done2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
